// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
//   Resolves one control-flow instruction at a time. A request is accepted in
//   IDLE, its operands are registered, and the resolved result is presented in
//   EVAL. A taken, aligned target is then held in REDIR as a redirect request
//   until fetch acknowledges it.
//
//   Contains:
//     branch_cmp  - branch/jump condition evaluator (the "taken" decision)
//     branch_ctrl - request capture, target/link generation, FSM, counters
//
// Ports (branch_ctrl)
//   clk, rst                 clock, synchronous active-high reset
//   i_valid / o_ready        request handshake
//   i_pc, i_op, i_funct3     instruction fields
//   i_rs1, i_rs2, i_imm      operands and sign-extended immediate
//   o_redirect, o_target     redirect request to fetch and its target
//   i_redir_ack              fetch accepts the redirect
//   o_flush                  one-cycle flush, issued with the redirect ack
//   o_link_we, o_link_data   link-register write (pc + 4) for jumps
//   o_misalign               one-cycle fault for a taken target with bit 1 set
//   o_br_cnt, o_taken_cnt    saturating counts of resolved / taken control ops
// -----------------------------------------------------------------------------

module branch_cmp (
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken
);
    logic is_branch;
    logic is_jump;

    assign is_branch = (op == 7'b1100011);
    assign is_jump   = (op[6:4] == 3'b110) && (op[2:0] == 3'b111);

    always_comb begin
        taken = 1'b0;
        if (is_jump) begin
            taken = 1'b1;
        end else if (is_branch) begin
            case (funct3)
                3'b000:  taken = (rs1 == rs2);
                3'b001:  taken = (rs1 != rs2);
                3'b100:  taken = ($signed(rs1) <  $signed(rs2));
                3'b101:  taken = ($signed(rs1) >= $signed(rs2));
                3'b110:  taken = (rs1 <  rs2);
                3'b111:  taken = (rs1 >= rs2);
                default: taken = 1'b0;
            endcase
        end
    end
endmodule

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request, o_target reads 0
// EVAL  | captured op resolved: link write, misalign fault, counters
// REDIR | redirect held to fetch until i_redir_ack, flush on the ack cycle
module branch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_pc,
    input  logic [6:0]  i_op,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_imm,
    output logic        o_redirect,
    output logic [31:0] o_target,
    input  logic        i_redir_ack,
    output logic        o_flush,
    output logic        o_link_we,
    output logic [31:0] o_link_data,
    output logic        o_misalign,
    output logic [15:0] o_br_cnt,
    output logic [15:0] o_taken_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        REDIR = 2'd2
    } state_t;

    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc_q;
    logic [6:0]  op_q;
    logic [2:0]  funct3_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;

    logic [15:0] br_cnt_q;
    logic [15:0] taken_cnt_q;

    logic        accept;
    logic        taken;
    logic        is_ctrl;
    logic        is_jump;
    logic [31:0] pc_imm;
    logic [31:0] rs1_imm;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign accept = i_valid && o_ready;

    branch_cmp u_cmp (
        .op     (op_q),
        .funct3 (funct3_q),
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .taken  (taken)
    );

    assign is_ctrl  = (op_q[6:4] == 3'b110);
    assign is_jump  = is_ctrl && (op_q[2:0] == 3'b111);
    assign pc_imm   = pc_q + imm_q;
    assign rs1_imm  = rs1_q + imm_q;
    assign pc_plus4 = pc_q + 32'd4;
    // JALR drops bit 0 of the computed address; everything else is pc-relative.
    assign target   = (op_q == OP_JALR) ? (rs1_imm & 32'hFFFF_FFFE) : pc_imm;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = EVAL;
            end
            EVAL: begin
                // A misaligned taken target faults instead of redirecting.
                if (taken && !target[1]) state_nxt = REDIR;
                else                     state_nxt = IDLE;
            end
            REDIR: begin
                if (i_redir_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_ready     = 1'b0;
        o_redirect  = 1'b0;
        o_flush     = 1'b0;
        o_link_we   = 1'b0;
        o_link_data = 32'd0;
        o_misalign  = 1'b0;
        o_target    = 32'd0;
        case (state)
            IDLE: begin
                o_ready = !rst;
            end
            EVAL: begin
                o_target    = target;
                o_link_we   = is_jump;
                o_link_data = is_jump ? pc_plus4 : 32'd0;
                o_misalign  = taken && target[1];
            end
            REDIR: begin
                o_target   = target;
                o_redirect = 1'b1;
                // An ack coinciding with reset is dropped: no flush.
                o_flush    = i_redir_ack && !rst;
            end
            default: ;
        endcase
    end

    // Request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= 32'd0;
            op_q     <= 7'd0;
            funct3_q <= 3'd0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            imm_q    <= 32'd0;
        end else if (accept) begin
            pc_q     <= i_pc;
            op_q     <= i_op;
            funct3_q <= i_funct3;
            rs1_q    <= i_rs1;
            rs2_q    <= i_rs2;
            imm_q    <= i_imm;
        end
    end

    // Saturating statistics counters, updated once per EVAL cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q    <= 16'd0;
            taken_cnt_q <= 16'd0;
        end else if (state == EVAL) begin
            if (is_ctrl && (br_cnt_q != 16'hFFFF)) begin
                br_cnt_q <= br_cnt_q + 16'd1;
            end
            if (taken && (taken_cnt_q != 16'hFFFF)) begin
                taken_cnt_q <= taken_cnt_q + 16'd1;
            end
        end
    end

    assign o_br_cnt    = br_cnt_q;
    assign o_taken_cnt = taken_cnt_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
//   Directed bench for branch_ctrl: a table of hand-computed vectors run
//   through the full request/evaluate/redirect handshake, followed by
//   hand-written sequences for reset priority and counter saturation.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------

module tb_branch_ctrl;
    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc;
    logic [6:0]  i_op;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [31:0] i_imm;
    logic        o_redirect;
    logic [31:0] o_target;
    logic        i_redir_ack;
    logic        o_flush;
    logic        o_link_we;
    logic [31:0] o_link_data;
    logic        o_misalign;
    logic [15:0] o_br_cnt;
    logic [15:0] o_taken_cnt;

    branch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_pc        (i_pc),
        .i_op        (i_op),
        .i_funct3    (i_funct3),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_imm       (i_imm),
        .o_redirect  (o_redirect),
        .o_target    (o_target),
        .i_redir_ack (i_redir_ack),
        .o_flush     (o_flush),
        .o_link_we   (o_link_we),
        .o_link_data (o_link_data),
        .o_misalign  (o_misalign),
        .o_br_cnt    (o_br_cnt),
        .o_taken_cnt (o_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        ctrl;
        logic        taken;
        logic [31:0] target;
        logic        link_we;
        logic [31:0] link;
        logic        mis;
    } vec_t;

    localparam int NVEC = 13;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    vec_t        vecs[NVEC];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_br = 16'd0;
    logic [15:0] exp_tk = 16'd0;

    function automatic vec_t mk(
        input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
        input logic ctrl, input logic taken, input logic [31:0] target,
        input logic link_we, input logic [31:0] link, input logic mis);
        vec_t v;
        v.pc = pc; v.op = op; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.ctrl = ctrl; v.taken = taken; v.target = target;
        v.link_we = link_we; v.link = link; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        i_pc     = v.pc;
        i_op     = v.op;
        i_funct3 = v.f3;
        i_rs1    = v.rs1;
        i_rs2    = v.rs2;
        i_imm    = v.imm;
    endtask

    task automatic scramble_inputs();
        i_pc     = 32'hDEAD_BEE0;
        i_op     = 7'b1101111;
        i_funct3 = 3'b001;
        i_rs1    = 32'h1234_5678;
        i_rs2    = 32'h8765_4321;
        i_imm    = 32'h0000_0F00;
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Entered just after a falling edge with the DUT in IDLE; leaves it the same way.
    task automatic run_vec(input vec_t v, input int idx);
        drive_req(v);
        i_valid = 1'b1;
        #1;
        chk($sformatf("v%0d ready_idle", idx), 32'(o_ready), 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        scramble_inputs();
        #1;
        chk($sformatf("v%0d eval_target", idx), o_target, v.target);
        chk($sformatf("v%0d eval_link_we", idx), 32'(o_link_we), 32'(v.link_we));
        chk($sformatf("v%0d eval_link_data", idx), o_link_data, v.link_we ? v.link : 32'd0);
        chk($sformatf("v%0d eval_misalign", idx), 32'(o_misalign), 32'(v.mis));
        chk($sformatf("v%0d eval_redirect", idx), 32'(o_redirect), 32'd0);
        if (v.ctrl)  exp_br = sat_inc(exp_br);
        if (v.taken) exp_tk = sat_inc(exp_tk);
        @(negedge clk);
        #1;
        if (v.taken && !v.mis) begin
            chk($sformatf("v%0d redir_redirect", idx), 32'(o_redirect), 32'd1);
            chk($sformatf("v%0d redir_target", idx), o_target, v.target);
            chk($sformatf("v%0d redir_noflush", idx), 32'(o_flush), 32'd0);
            chk($sformatf("v%0d redir_ready", idx), 32'(o_ready), 32'd0);
            i_redir_ack = 1'b1;
            #1;
            chk($sformatf("v%0d ack_flush", idx), 32'(o_flush), 32'd1);
            @(negedge clk);
            i_redir_ack = 1'b0;
            #1;
        end
        chk($sformatf("v%0d back_ready", idx), 32'(o_ready), 32'd1);
        chk($sformatf("v%0d back_redirect", idx), 32'(o_redirect), 32'd0);
        chk($sformatf("v%0d back_flush", idx), 32'(o_flush), 32'd0);
        chk($sformatf("v%0d back_target", idx), o_target, 32'd0);
        chk($sformatf("v%0d br_cnt", idx), 32'(o_br_cnt), 32'(exp_br));
        chk($sformatf("v%0d taken_cnt", idx), 32'(o_taken_cnt), 32'(exp_tk));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t beq;
        //            pc            op       f3      rs1           rs2           imm           ctrl  tk    target        lwe   link          mis
        vecs[0]  = mk(32'h100,      OP_BR,   3'b000, 32'd5,        32'd5,        32'h20,       1'b1, 1'b1, 32'h120,      1'b0, 32'h0,        1'b0);
        vecs[1]  = mk(32'h300,      OP_BR,   3'b110, 32'd9,        32'd3,        32'h40,       1'b1, 1'b0, 32'h340,      1'b0, 32'h0,        1'b0);
        vecs[2]  = mk(32'h200,      OP_JALR, 3'b000, 32'h1001,     32'd0,        32'h4,        1'b1, 1'b1, 32'h1004,     1'b1, 32'h204,      1'b0);
        vecs[3]  = mk(32'h0,        OP_JAL,  3'b000, 32'd0,        32'd0,        32'h6,        1'b1, 1'b1, 32'h6,        1'b1, 32'h4,        1'b1);
        vecs[4]  = mk(32'h1000,     OP_BR,   3'b001, 32'd1,        32'd2,        32'hFFFF_FFF0,1'b1, 1'b1, 32'hFF0,      1'b0, 32'h0,        1'b0);
        vecs[5]  = mk(32'h40,       OP_BR,   3'b100, 32'hFFFF_FFFF,32'd1,        32'h8,        1'b1, 1'b1, 32'h48,       1'b0, 32'h0,        1'b0);
        vecs[6]  = mk(32'h40,       OP_BR,   3'b101, 32'hFFFF_FFFF,32'd1,        32'h8,        1'b1, 1'b0, 32'h48,       1'b0, 32'h0,        1'b0);
        vecs[7]  = mk(32'hFFFF_FFF0,OP_BR,   3'b111, 32'hFFFF_FFFF,32'd1,        32'h20,       1'b1, 1'b1, 32'h10,       1'b0, 32'h0,        1'b0);
        vecs[8]  = mk(32'h50,       OP_ADDI, 3'b000, 32'd5,        32'd5,        32'h4,        1'b0, 1'b0, 32'h54,       1'b0, 32'h0,        1'b0);
        vecs[9]  = mk(32'hFFFF_FFFC,OP_JALR, 3'b000, 32'hFFFF_FFFE,32'd0,        32'h6,        1'b1, 1'b1, 32'h4,        1'b1, 32'h0,        1'b0);
        vecs[10] = mk(32'h80,       OP_BR,   3'b000, 32'd5,        32'd6,        32'h10,       1'b1, 1'b0, 32'h90,       1'b0, 32'h0,        1'b0);
        vecs[11] = mk(32'h10,       OP_BR,   3'b000, 32'd0,        32'd0,        32'h2,        1'b1, 1'b1, 32'h12,       1'b0, 32'h0,        1'b1);
        vecs[12] = mk(32'h60,       OP_BR,   3'b010, 32'd7,        32'd7,        32'h10,       1'b1, 1'b0, 32'h70,       1'b0, 32'h0,        1'b0);
        beq = vecs[0];

        // Reset, with a request pending that must not be captured.
        rst = 1'b1;
        i_redir_ack = 1'b0;
        drive_req(beq);
        i_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst ready_low", 32'(o_ready), 32'd0);
        chk("rst redirect", 32'(o_redirect), 32'd0);
        chk("rst target", o_target, 32'd0);
        chk("rst br_cnt", 32'(o_br_cnt), 32'd0);
        chk("rst taken_cnt", 32'(o_taken_cnt), 32'd0);
        rst = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("rst_release ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_release target", o_target, 32'd0);
        chk("rst_release link_we", 32'(o_link_we), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Redirect held unacknowledged, then reset arrives together with an ack.
        drive_req(beq);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("hold%0d redirect", k), 32'(o_redirect), 32'd1);
            chk($sformatf("hold%0d target", k), o_target, 32'h120);
            chk($sformatf("hold%0d flush", k), 32'(o_flush), 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        i_redir_ack = 1'b1;
        #1;
        chk("rst_ack flush", 32'(o_flush), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        i_redir_ack = 1'b0;
        #1;
        chk("rst_redir redirect", 32'(o_redirect), 32'd0);
        chk("rst_redir flush", 32'(o_flush), 32'd0);
        chk("rst_redir ready", 32'(o_ready), 32'd1);
        chk("rst_redir br_cnt", 32'(o_br_cnt), 32'd0);
        chk("rst_redir taken_cnt", 32'(o_taken_cnt), 32'd0);
        exp_br = 16'd0;
        exp_tk = 16'd0;

        // Reset wins over an acceptance in IDLE.
        drive_req(beq);
        i_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_accept ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("rst_accept target", o_target, 32'd0);
        chk("rst_accept ready_after", 32'(o_ready), 32'd1);

        // Saturation: counters preloaded one below the limit.
        force dut.br_cnt_q = 16'hFFFE;
        force dut.taken_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.br_cnt_q;
        release dut.taken_cnt_q;
        #1;
        chk("preload br_cnt", 32'(o_br_cnt), 32'hFFFE);
        chk("preload taken_cnt", 32'(o_taken_cnt), 32'hFFFE);
        exp_br = 16'hFFFE;
        exp_tk = 16'hFFFE;
        run_vec(beq, 100);
        run_vec(vecs[3], 101);

        // Back-to-back valid while a redirect is outstanding must be ignored.
        drive_req(beq);
        i_valid = 1'b1;
        @(negedge clk);
        i_pc  = 32'h900;
        i_imm = 32'h44;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("b2b%0d ready", k), 32'(o_ready), 32'd0);
            chk($sformatf("b2b%0d target", k), o_target, 32'h120);
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_redir_ack = 1'b1;
        #1;
        chk("b2b ack_flush", 32'(o_flush), 32'd1);
        @(negedge clk);
        i_redir_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("b2b not_captured", o_target, 32'd0);
        chk("b2b br_cnt_sat", 32'(o_br_cnt), 32'hFFFF);
        chk("b2b taken_cnt_sat", 32'(o_taken_cnt), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  request accept.
- i_pc  in  32  PC of the instruction.
- i_op  in  7  opcode.
- i_funct3  in  3  funct3.
- i_rs1  in  32  rs1 operand.
- i_rs2  in  32  rs2 operand.
- i_imm  in  32  sign-extended immediate.
- o_redirect  out  1  redirect request to fetch.
- o_target  out  32  redirect target.
- i_redir_ack  in  1  fetch accepts the redirect.
- o_flush  out  1  one-cycle pipeline flush pulse.
- o_link_we  out  1  link-register write strobe.
- o_link_data  out  32  link value.
- o_misalign  out  1  one-cycle misaligned-target fault pulse.
- o_br_cnt  out  16  count of resolved control ops.
- o_taken_cnt  out  16  count of taken control ops.
REQ-002 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, EVAL and REDIR.
REQ-004 o_ready SHALL be 1 only in IDLE with rst low.
- A request is accepted when i_valid and o_ready are both 1.
- On acceptance, pc, op, funct3, rs1, rs2 and imm SHALL be captured into registers and the FSM SHALL go to EVAL.
REQ-005 The branch condition SHALL be produced by instantiating the team comparator on the captured op, funct3, rs1 and rs2.
- The comparator result is "taken".
- Non-control ops (op[6:4] != 110) give taken = 0.
REQ-006 The target SHALL be selected by captured op:
- op == 1100111 (JALR): target = (rs1 + imm) with bit 0 cleared.
- All other ops: target = pc + imm.
- Arithmetic is modulo 2^32, wrapping with no overflow flag.
REQ-007 For a jump (op[6:4] == 110 and op[2:0] == 111), the block SHALL assert o_link_we for exactly the EVAL cycle.
- o_link_data = pc + 4, wrapping, during that cycle.
- The link write SHALL occur even when o_misalign fires.
REQ-008 In EVAL, when taken = 1 and target[1] = 1, the block SHALL:
- pulse o_misalign for that cycle;
- not assert o_redirect;
- return to IDLE.
REQ-009 In EVAL, when taken = 1 and target[1] = 0, the FSM SHALL go to REDIR.
REQ-010 In EVAL, when taken = 0, the FSM SHALL return to IDLE with no redirect and no flush.
REQ-011 In REDIR, o_redirect SHALL be 1 and o_target SHALL be held stable until i_redir_ack is sampled 1.
- o_flush SHALL be 1 in that same ack cycle only.
- The FSM SHALL go to IDLE on the next edge.
- i_redir_ack outside REDIR SHALL be ignored.
REQ-012 Minimum request throughput SHALL be one request per 2 cycles (not taken) and one per 3 cycles (taken with immediate ack).
REQ-013 o_br_cnt SHALL increment by 1 in each EVAL cycle whose op[6:4] == 110.
- o_taken_cnt SHALL increment in each EVAL cycle with taken = 1, including misaligned cases.
- Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-014 i_valid held high while o_ready = 0 SHALL have no effect and SHALL NOT be captured.
REQ-015 o_target SHALL read 0 in IDLE and the computed target in EVAL and REDIR.

Reset
REQ-016 On rst = 1 at a rising edge, the block SHALL:
- set the FSM to IDLE;
- clear all captured registers and both counters;
- drive o_redirect, o_flush, o_link_we, o_misalign, o_target and o_link_data to 0 from the next cycle.
REQ-017 Reset SHALL take priority over every other event, including an ack in REDIR or an acceptance in IDLE. An in-flight redirect SHALL be dropped with no flush.
REQ-018 o_ready SHALL be 0 while rst is high and SHALL be 1 in the first cycle after rst falls.

Verification
REQ-019 The bench SHALL cover at least these scenarios:
- BEQ: op=1100011, f3=000, rs1=rs2=5, pc=0x100, imm=0x20 -> REDIR, o_target=0x120; ack -> o_flush for 1 cycle; o_br_cnt=1, o_taken_cnt=1.
- BLTU not taken: f3=110, rs1=9, rs2=3 -> IDLE after EVAL, no redirect or flush, o_ready=1 in cycle 3, o_taken_cnt unchanged.
- JALR: rs1=0x1001, imm=0x4, pc=0x200 -> o_target=0x1004, o_link_we=1 with o_link_data=0x204 in EVAL.
- JAL misaligned: pc=0x0, imm=0x6 -> o_misalign pulse, o_link_we=1 with link=0x4, no o_redirect.
- Reset mid-REDIR with ack held low for 5 cycles, then rst=1 -> o_redirect=0 next cycle, no o_flush ever, counters=0.
- Saturation: preload 65535 taken branches, then 1 more -> o_taken_cnt stays 0xFFFF; a second ack-free back-to-back i_valid is not captured during REDIR.
